seq_alu: RTL and testbench

Parametrised, registered successor to the 16-bit combinational datapath ALU. It adds iterative multiply and divide (one bit per cycle), barrel shifts, carry/borrow and zero flags, and a start/busy/done handshake. It sits between the register-file read buses and the C bus write-back. The sequencer issues one operation at a time and writes the result back when `done` pulses.

---
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle logic/arith ops and iterative (1 bit/cycle)
// multiply and restoring divide behind a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a_bus,
  input  logic [WIDTH-1:0] b_bus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c_bus,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MUL_RUN = 2'd1;
  localparam logic [1:0] DIV_RUN = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_PASS = 3'd2;
  localparam logic [2:0] OP_ZER  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_DIV  = 3'd7;

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   c_r;
  logic               z_r;
  logic               cf_r;
  logic               done_r;
  logic               busy_r;

  logic [SHW-1:0]     shamt_s;
  logic [WIDTH:0]     ext_s;
  logic [WIDTH-1:0]   one_res_s;
  logic               one_c_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] step_next_s;
  logic [WIDTH-1:0]   fin_res_s;
  logic               fin_c_s;

  assign shamt_s = b_bus[SHW-1:0];

  // Result and carry for the ops that finish in the issue cycle.
  always_comb begin
    ext_s     = {(WIDTH+1){1'b0}};
    one_res_s = {WIDTH{1'b0}};
    one_c_s   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        ext_s     = {1'b0, a_bus} + {1'b0, b_bus};
        one_res_s = ext_s[WIDTH-1:0];
        one_c_s   = ext_s[WIDTH];
      end
      OP_SUB: begin
        ext_s     = {1'b0, a_bus} - {1'b0, b_bus};
        one_res_s = ext_s[WIDTH-1:0];
        one_c_s   = ext_s[WIDTH];
      end
      OP_PASS: one_res_s = b_bus;
      OP_ZER:  one_res_s = {WIDTH{1'b0}};
      OP_MUL:  one_res_s = {WIDTH{1'b0}};
      OP_SHL:  one_res_s = a_bus << shamt_s;
      OP_SHR:  one_res_s = a_bus >> shamt_s;
      OP_DIV: begin
        one_res_s = {WIDTH{1'b1}};
        one_c_s   = 1'b1;
      end
      default: one_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc_r[0] ? opnd_r : {WIDTH{1'b0}})};
    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (state_r == DIV_RUN) begin
      if (div_diff_s[WIDTH]) begin
        step_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end else begin
        step_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end
      fin_c_s = 1'b0;
    end else begin
      step_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      fin_c_s     = |step_next_s[2*WIDTH-1:WIDTH];
    end
    fin_res_s = step_next_s[WIDTH-1:0];
  end

  // Sequencer, iteration state and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      c_r     <= {WIDTH{1'b0}};
      z_r     <= 1'b0;
      cf_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (alu_op == OP_MUL) begin
              acc_r   <= {{WIDTH{1'b0}}, b_bus};
              opnd_r  <= a_bus;
              cnt_r   <= CW'(WIDTH);
              state_r <= MUL_RUN;
              busy_r  <= 1'b1;
            end else if ((alu_op == OP_DIV) && (b_bus != {WIDTH{1'b0}})) begin
              acc_r   <= {{WIDTH{1'b0}}, a_bus};
              opnd_r  <= b_bus;
              cnt_r   <= CW'(WIDTH);
              state_r <= DIV_RUN;
              busy_r  <= 1'b1;
            end else begin
              c_r    <= one_res_s;
              z_r    <= (one_res_s == {WIDTH{1'b0}});
              cf_r   <= one_c_s;
              done_r <= 1'b1;
            end
          end
        end
        MUL_RUN, DIV_RUN: begin
          acc_r <= step_next_s;
          if (cnt_r == CW'(1)) begin
            c_r     <= fin_res_s;
            z_r     <= (fin_res_s == {WIDTH{1'b0}});
            cf_r    <= fin_c_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign c_bus  = c_r;
  assign flag_z = z_r;
  assign flag_c = cf_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus random ops checked
// against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   alu_op;
  logic [W-1:0] a_bus;
  logic [W-1:0] b_bus;
  logic         busy;
  logic         done;
  logic [W-1:0] c_bus;
  logic         flag_z;
  logic         flag_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_op(alu_op),
    .a_bus(a_bus), .b_bus(b_bus), .busy(busy), .done(done),
    .c_bus(c_bus), .flag_z(flag_z), .flag_c(flag_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, latency in cycles from issue edge to done.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output int lat);
    longint unsigned p;
    longint unsigned ua = a;
    longint unsigned ub = b;
    c = 1'b0;
    lat = 1;
    r = '0;
    case (op)
      3'd0: begin p = ua + ub; r = W'(p % 65536); c = (p >= 65536); end
      3'd1: begin p = (ua + 65536 - ub) % 65536; r = W'(p); c = (ua < ub); end
      3'd2: r = b;
      3'd3: r = '0;
      3'd4: begin p = ua * ub; r = W'(p % 65536); c = (p >= 65536); lat = W + 1; end
      3'd5: begin p = (ua * (64'd1 << (ub % W))) % 65536; r = W'(p); end
      3'd6: begin p = ua / (64'd1 << (ub % W)); r = W'(p); end
      default: begin
        if (ub == 0) begin r = '1; c = 1'b1; end
        else begin r = W'(ua / ub); lat = W + 1; end
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; alu_op = op; a_bus = a; b_bus = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits (bounded) for done; optionally pulses start at cycle inj_k or in the done cycle.
  task automatic wait_done(input int inj_k, input bit inj_done, input logic [2:0] iop,
                           input logic [W-1:0] ia, input logic [W-1:0] ib,
                           output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (k == inj_k) begin
        start = 1'b1; alu_op = iop; a_bus = ia; b_bus = ib;
      end
      if (done) begin
        lat = k;
        if (inj_done) begin
          start = 1'b1; alu_op = iop; a_bus = ia; b_bus = ib;
          @(posedge clk);
          #1 start = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj_k);
    logic [W-1:0] er;
    logic ec;
    int elat, lat, bcnt;
    model(op, a, b, er, ec, elat);
    issue(op, a, b);
    wait_done(inj_k, 1'b0, 3'd0, 16'd1, 16'd1, lat, bcnt);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, bcnt, elat - 1);
    check({tag, "_c"}, c_bus, er);
    check({tag, "_z"}, flag_z, (er == 0));
    check({tag, "_fc"}, flag_c, ec);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check({tag, "_nodone"}, done, 1'b0);
      check({tag, "_hold"}, c_bus, er);
    end
  endtask

  initial begin
    logic [W-1:0] r1, r2, ra, rb;
    logic c1, c2;
    logic [2:0] rop;
    int l1, l2, lat, bcnt, dcnt;

    rst_n = 1'b0; start = 1'b0; alu_op = 3'd0; a_bus = '0; b_bus = '0;
    repeat (3) @(negedge clk);
    check("rst_c", c_bus, 0);
    check("rst_z", flag_z, 0);
    check("rst_fc", flag_c, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 0);
    check("add_wrap_lit", {flag_c, flag_z, c_bus}, {2'b11, 16'h0000});
    run_op("sub_borrow", 3'd1, 16'd5, 16'd7, 0);
    check("sub_borrow_lit", {flag_c, c_bus}, {1'b1, 16'hFFFE});

    run_op("mul_300", 3'd4, 16'd300, 16'd300, 5);
    check("mul_300_lit", {flag_c, c_bus}, {1'b1, 16'h5F90});

    run_op("div_1000_7", 3'd7, 16'd1000, 16'd7, 0);
    check("div_lit", c_bus, 16'h008E);
    run_op("div_zero", 3'd7, 16'd5, 16'd0, 0);
    check("div_zero_lit", {flag_c, c_bus}, {1'b1, 16'hFFFF});

    run_op("shl", 3'd5, 16'h0001, 16'h0013, 0);
    check("shl_lit", c_bus, 16'h0008);
    run_op("shr", 3'd6, 16'h8000, 16'd15, 0);
    check("shr_lit", c_bus, 16'h0001);
    run_op("pass0", 3'd2, 16'h1234, 16'h0000, 0);
    run_op("zer", 3'd3, 16'hABCD, 16'h1234, 0);

    // Reset in the middle of a multiply aborts it.
    issue(3'd4, 16'd300, 16'd300);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_c", c_bus, 0);
    check("abort_z", flag_z, 0);
    check("abort_fc", flag_c, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    dcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("abort_nodone", dcnt, 0);
    check("abort_nobusy", bcnt, 0);
    run_op("add_after_rst", 3'd0, 16'd2, 16'd3, 0);

    // Back-to-back: DIV issued in the MUL done cycle.
    model(3'd4, 16'd3, 16'd4, r1, c1, l1);
    model(3'd7, 16'd12, 16'd4, r2, c2, l2);
    issue(3'd4, 16'd3, 16'd4);
    wait_done(0, 1'b1, 3'd7, 16'd12, 16'd4, lat, bcnt);
    check("b2b_mul_lat", lat, l1);
    check("b2b_mul_c", c_bus, r1);
    wait_done(0, 1'b0, 3'd0, 16'd0, 16'd0, lat, bcnt);
    check("b2b_div_lat", lat, l2);
    check("b2b_div_busy", bcnt, W);
    check("b2b_div_c", c_bus, r2);
    check("b2b_div_fc", flag_c, c2);

    for (int i = 0; i < 50; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      run_op("rand", rop, ra, rb, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
